// File: rtl/seg_scroll_driver_if.sv
// Write port into the scrolling display's message buffer.
// The control side drives it through master, the display driver receives it through slave.
interface seg_scroll_driver_if #(
  parameter int MSG_LEN = 16
);
  logic                       wr_en;
  logic [$clog2(MSG_LEN)-1:0] wr_addr;
  logic [4:0]                 wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/seg_scroll_driver.sv
// Multiplexed common-anode 7-segment driver showing a DIGITS-wide window of a message
// buffer, with circular or paged scrolling and four-level per-digit PWM brightness.
module seg_scroll_driver #(
  parameter int DIGITS   = 4,
  parameter int MSG_LEN  = 16,
  parameter int SCAN_DIV = 625,
  parameter int STEP_DIV = 25000000
) (
  input  logic                       clk,
  input  logic                       rst_n,
  seg_scroll_driver_if.slave         wr_bus,
  input  logic [$clog2(MSG_LEN):0]   msg_len,
  input  logic                       mode,
  input  logic                       hold,
  input  logic [1:0]                 light,
  output logic [6:0]                 num,
  output logic [DIGITS-1:0]          en,
  output logic                       wrap
);

  localparam int AW  = $clog2(MSG_LEN);
  localparam int DW  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SCW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int STW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [AW:0] PAGE_STEP = (AW+1)'(DIGITS);

  logic [SCW-1:0]    scan_cnt;
  logic [STW-1:0]    step_cnt;
  logic              scan_tick;
  logic              step_tick;
  logic [4:0]        msg_buf [MSG_LEN];
  logic [AW-1:0]     ptr;
  logic [AW-1:0]     ptr_next;
  logic [AW:0]       ptr_sum;
  logic              len_zero;
  logic              step_update;
  logic [3:0]        sub_cnt;
  logic [DW-1:0]     dig_idx;
  logic [AW:0]       idx_sum;
  logic [AW-1:0]     idx_mod;
  logic [4:0]        cur_char;
  logic [4:0]        duty_lim;
  logic              lit;
  logic [DIGITS-1:0] en_next;

  function automatic logic [6:0] seg_decode(input logic [4:0] c);
    logic [6:0] s;
    if (c[4]) begin
      s = 7'h7F;
    end else begin
      case (c[3:0])
        4'h0: s = 7'h40;
        4'h1: s = 7'h79;
        4'h2: s = 7'h24;
        4'h3: s = 7'h30;
        4'h4: s = 7'h19;
        4'h5: s = 7'h12;
        4'h6: s = 7'h02;
        4'h7: s = 7'h78;
        4'h8: s = 7'h00;
        4'h9: s = 7'h10;
        4'hA: s = 7'h08;
        4'hB: s = 7'h03;
        4'hC: s = 7'h46;
        4'hD: s = 7'h21;
        4'hE: s = 7'h06;
        default: s = 7'h0E;
      endcase
    end
    return s;
  endfunction

  assign scan_tick = (scan_cnt == SCW'(SCAN_DIV - 1));
  assign step_tick = (step_cnt == STW'(STEP_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt <= '0;
      step_cnt <= '0;
    end else begin
      scan_cnt <= scan_tick ? '0 : scan_cnt + SCW'(1);
      step_cnt <= step_tick ? '0 : step_cnt + STW'(1);
    end
  end

  // Same-cycle reads see the pre-write contents since the read path is combinational.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MSG_LEN; i++) msg_buf[i] <= 5'h10;
    end else if (wr_bus.wr_en) begin
      msg_buf[wr_bus.wr_addr] <= wr_bus.wr_data;
    end
  end

  // A pointer left past a shrunken message overflows the compare and returns to 0.
  always_comb begin
    len_zero    = (msg_len == '0);
    step_update = step_tick && !hold;
    ptr_sum     = {1'b0, ptr} + (mode ? PAGE_STEP : (AW+1)'(1));
    ptr_next    = ptr;
    if (len_zero || (ptr_sum >= msg_len)) begin
      ptr_next = '0;
    end else begin
      ptr_next = ptr_sum[AW-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr  <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= step_update && !len_zero && (ptr != '0) && (ptr_next == '0);
      if (step_update) ptr <= ptr_next;
    end
  end

  always_comb begin
    idx_sum  = {1'b0, ptr} + (AW+1)'(dig_idx);
    idx_mod  = '0;
    cur_char = 5'h10;
    if (!len_zero) begin
      if (!mode) begin
        idx_mod  = AW'(idx_sum % msg_len);
        cur_char = msg_buf[idx_mod];
      end else if (idx_sum < msg_len) begin
        cur_char = msg_buf[idx_sum[AW-1:0]];
      end
    end
  end

  always_comb begin
    duty_lim = {1'b0, light, 2'b00} + 5'd4;
    lit      = ({1'b0, sub_cnt} < duty_lim);
    en_next  = '1;
    if (lit) en_next[dig_idx] = 1'b0;
  end

  // Each digit owns 16 consecutive sub-ticks; brightness gates the first 4*(light+1) of them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_cnt <= '0;
      dig_idx <= '0;
      num     <= 7'h7F;
      en      <= '1;
    end else if (scan_tick) begin
      sub_cnt <= sub_cnt + 4'd1;
      if (sub_cnt == 4'hF) begin
        dig_idx <= (dig_idx == DW'(DIGITS - 1)) ? '0 : dig_idx + DW'(1);
      end
      num <= seg_decode(cur_char);
      en  <= en_next;
    end
  end

endmodule

// File: tb/tb_seg_scroll_driver.sv
// Directed bench for seg_scroll_driver: reset, circular and paged scrolling, brightness,
// zero-length message, hold, shrink and write/read collision.
module tb_seg_scroll_driver;

  localparam int DIGITS   = 4;
  localparam int MSG_LEN  = 8;
  localparam int SCAN_DIV = 2;
  localparam int STEP_DIV = 128;

  localparam logic [27:0] W_2017  = {7'h24, 7'h40, 7'h79, 7'h78};
  localparam logic [27:0] W_PAGE2 = {7'h40, 7'h30, 7'h7F, 7'h7F};
  localparam logic [27:0] W_2020  = {7'h24, 7'h40, 7'h24, 7'h40};
  localparam logic [27:0] W_8080  = {7'h00, 7'h40, 7'h00, 7'h40};
  localparam logic [27:0] CIRC [7] = '{
    {7'h24, 7'h40, 7'h79, 7'h78},
    {7'h40, 7'h79, 7'h78, 7'h40},
    {7'h79, 7'h78, 7'h40, 7'h30},
    {7'h78, 7'h40, 7'h30, 7'h24},
    {7'h40, 7'h30, 7'h24, 7'h40},
    {7'h30, 7'h24, 7'h40, 7'h79},
    {7'h24, 7'h40, 7'h79, 7'h78}
  };
  localparam logic [4:0] MSG [6] = '{5'h02, 5'h00, 5'h01, 5'h07, 5'h00, 5'h03};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  msg_len;
  logic        mode;
  logic        hold;
  logic [1:0]  light;
  logic [6:0]  num;
  logic [3:0]  en;
  logic        wrap;

  int tests_run = 0;
  int tests_failed = 0;
  int wrap_cycles = 0;
  int wrap_mark;
  logic [27:0] win;

  seg_scroll_driver_if #(.MSG_LEN(MSG_LEN)) wr_bus ();

  seg_scroll_driver #(
    .DIGITS(DIGITS), .MSG_LEN(MSG_LEN), .SCAN_DIV(SCAN_DIV), .STEP_DIV(STEP_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_bus(wr_bus), .msg_len(msg_len), .mode(mode),
    .hold(hold), .light(light), .num(num), .en(en), .wrap(wrap)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (wrap === 1'b1) wrap_cycles++;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] addr, input logic [4:0] data);
    wr_bus.wr_en   = 1'b1;
    wr_bus.wr_addr = addr;
    wr_bus.wr_data = data;
    @(negedge clk);
    wr_bus.wr_en   = 1'b0;
  endtask

  task automatic writeMessage();
    for (int i = 0; i < 6; i++) applyStimulus(3'(i), MSG[i]);
  endtask

  task automatic waitEn(input logic [3:0] target, input string tag);
    int n = 0;
    while (en !== target && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (en !== target) checkOutput({tag, "_timeout"}, {28'h0, en}, {28'h0, target});
  endtask

  // Skips to the start of the next full scan so the captured window belongs to one pointer value.
  task automatic readWindow(output logic [27:0] w);
    waitEn(4'b0111, "sync");
    waitEn(4'b1110, "dig0");
    w[27:21] = num;
    waitEn(4'b1101, "dig1");
    w[20:14] = num;
    waitEn(4'b1011, "dig2");
    w[13:7] = num;
    waitEn(4'b0111, "dig3");
    w[6:0] = num;
  endtask

  initial begin
    int n;
    int bad;
    int multi;
    int low [4];

    msg_len = 4'd6; mode = 1'b0; hold = 1'b1; light = 2'd3;
    wr_bus.wr_en = 1'b0; wr_bus.wr_addr = '0; wr_bus.wr_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    writeMessage();
    repeat (40) @(negedge clk);

    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_num", {25'h0, num}, 32'h7F);
    checkOutput("rst_en", {28'h0, en}, 32'hF);
    checkOutput("rst_wrap", {31'h0, wrap}, 32'h0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    while (en === 4'b1111 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("first_digit", {28'h0, en}, 32'hE);
    checkOutput("first_num", {25'h0, num}, 32'h7F);

    writeMessage();
    readWindow(win);
    checkOutput("circ_start", {4'h0, win}, {4'h0, W_2017});
    hold = 1'b0;
    wrap_mark = wrap_cycles;
    for (int s = 1; s <= 6; s++) begin
      readWindow(win);
      checkOutput($sformatf("circ_step%0d", s), {4'h0, win}, {4'h0, CIRC[s]});
    end
    checkOutput("circ_wrap", wrap_cycles - wrap_mark, 1);

    mode = 1'b1;
    wrap_mark = wrap_cycles;
    readWindow(win);
    checkOutput("page1", {4'h0, win}, {4'h0, W_PAGE2});
    checkOutput("page1_wrap", wrap_cycles - wrap_mark, 0);
    readWindow(win);
    checkOutput("page2", {4'h0, win}, {4'h0, W_2017});
    checkOutput("page2_wrap", wrap_cycles - wrap_mark, 1);

    for (int l = 0; l <= 2; l += 2) begin
      light = 2'(l);
      repeat (6) @(negedge clk);
      for (int k = 0; k < 4; k++) low[k] = 0;
      multi = 0;
      repeat (128) begin
        @(negedge clk);
        for (int k = 0; k < 4; k++) if (en[k] === 1'b0) low[k]++;
        if ($countones(~en) > 1) multi++;
      end
      for (int k = 0; k < 4; k++)
        checkOutput($sformatf("light%0d_en%0d", l, k), low[k], (l + 1) * 8);
      checkOutput($sformatf("light%0d_onehot", l), multi, 0);
    end

    light = 2'd3;
    mode = 1'b0;
    msg_len = 4'd0;
    repeat (4) @(negedge clk);
    wrap_mark = wrap_cycles;
    bad = 0;
    repeat (20 * STEP_DIV) begin
      @(negedge clk);
      if (num !== 7'h7F) bad++;
    end
    checkOutput("len0_blank", bad, 0);
    checkOutput("len0_wrap", wrap_cycles - wrap_mark, 0);

    msg_len = 4'd6;
    hold = 1'b1;
    wrap_mark = wrap_cycles;
    for (int s = 1; s <= 3; s++) begin
      readWindow(win);
      checkOutput($sformatf("hold_step%0d", s), {4'h0, win}, {4'h0, W_2017});
    end
    checkOutput("hold_wrap", wrap_cycles - wrap_mark, 0);

    hold = 1'b0;
    for (int s = 1; s <= 4; s++) begin
      readWindow(win);
      checkOutput($sformatf("resume_step%0d", s), {4'h0, win}, {4'h0, CIRC[s]});
    end

    msg_len = 4'd2;
    wrap_mark = wrap_cycles;
    readWindow(win);
    checkOutput("shrink_win", {4'h0, win}, {4'h0, W_2020});
    checkOutput("shrink_wrap", wrap_cycles - wrap_mark, 1);

    // The write lands on the same edge that registers the second digit-0 update.
    hold = 1'b1;
    waitEn(4'b0111, "coll_sync");
    waitEn(4'b1110, "coll_dig0");
    @(negedge clk);
    applyStimulus(3'd0, 5'h08);
    checkOutput("collide_old", {25'h0, num}, 32'h24);
    repeat (2) @(negedge clk);
    checkOutput("collide_new", {25'h0, num}, 32'h00);
    readWindow(win);
    checkOutput("collide_win", {4'h0, win}, {4'h0, W_8080});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/seg_scroll_driver.md
Name: seg_scroll_driver

Overview:
- Parametrised multiplexed 7-segment driver that shows a message window of DIGITS characters, taken from a writable message buffer.
- Scrolls the window at a programmable step rate, in circular or paged mode.
- Applies per-digit PWM brightness.
- Sits between control logic (which writes the message) and the board's common-anode display pins.

Parameters:
- DIGITS, 4, number of physical digits scanned (2..8).
- MSG_LEN, 16, message buffer depth in characters (≥ DIGITS, power of two).
- SCAN_DIV, 625, clk cycles per scan sub-tick.
- STEP_DIV, 25000000, clk cycles per scroll step.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write strobe for message buffer.
- wr_addr  in  log2(MSG_LEN)  character address.
- wr_data  in  5  bit4=blank, bits3:0 hex digit 0-F.
- msg_len  in  log2(MSG_LEN)+1  active message length, 0..MSG_LEN.
- mode  in  1  0=circular scroll, 1=paged.
- hold  in  1  1=freeze scroll pointer.
- light  in  2  brightness level 0..3.
- num  out  7  segments g..a, active-low.
- en  out  DIGITS  digit enables, active-low.
- wrap  out  1  one-cycle pulse when scroll pointer returns to 0.

Behaviour:
- Reset (async, rst_n=0):
  - buffer all blank (bit4=1); ptr=0; digit index=0; sub_cnt=0; both dividers=0.
  - num=7'h7F; en=all 1s; wrap=0.
- Dividers:
  - scan divider counts 0..SCAN_DIV-1; scan_tick is asserted for the clk cycle it equals SCAN_DIV-1, then it returns to 0.
  - step divider counts 0..STEP_DIV-1 the same way and produces step_tick.
  - Both free-run regardless of hold.
- Buffer writes:
  - Synchronous; take effect on the clk edge with wr_en=1.
  - A read of the same address in that cycle returns the old value.
  - wr_addr is fully decoded; there is no out-of-range case.
- Scroll pointer ptr (log2(MSG_LEN) bits), updated on step_tick when hold=0:
  - mode 0: ptr ← (ptr+1 ≥ msg_len) ? 0 : ptr+1.
  - mode 1: ptr ← (ptr+DIGITS ≥ msg_len) ? 0 : ptr+DIGITS.
  - wrap=1 for exactly the clk cycle after any update that sets ptr from nonzero to 0.
  - msg_len=0: ptr is forced to 0 and there is no wrap pulse.
  - msg_len or mode changing mid-run: the new value is used at the next step_tick, and the same wrap rule applies.
  - If ptr ≥ msg_len after a shrink, it is reset to 0 at the next step_tick, with a wrap pulse if ptr was nonzero.
- Character for digit k (k=0 is leftmost):
  - mode 0: idx=(ptr+k) mod msg_len (no modulo when msg_len=0).
  - mode 1: idx=ptr+k; blank if idx ≥ msg_len.
  - msg_len=0 shows all digits blank.
- Scan and brightness:
  - On each scan_tick, sub_cnt (4 bits) increments.
  - When sub_cnt wraps 15→0, the digit index advances modulo DIGITS.
  - Registered outputs update on scan_tick:
    - en[d]=0 only for d=digit index, and only while sub_cnt < 4*(light+1); otherwise all en=1.
    - num = decode(character of current digit).
  - Duty is therefore 4/16, 8/16, 12/16 or 16/16 for light=0..3.
- Decode (active-low g..a):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
  - blank=7F.
- Outputs are glitch-free: num and en change only on clk edges following scan_tick.

Test Plan:
- Bench parameters: DIGITS=4, MSG_LEN=8, SCAN_DIV=2, STEP_DIV=128.
- Reset: assert rst_n=0 mid-scan → num=7F, en=4'b1111, wrap=0 immediately. Release → ptr=0, digit 0 scanned first.
- Circular scroll:
  - Write 2,0,1,7,0,3 at addresses 0..5; msg_len=6; mode=0; light=3.
  - → digit window reads 2017 (num 24,40,79,78).
  - After 1 step the window is 0170; after 6 steps it is back to 2017, with a single wrap pulse on the 6th step.
- Paged mode: same message, mode=1 → pages 2017, then 03 followed by two blanks (7F,7F), then 2017; wrap on the second step.
- Brightness: light=0 → each en bit is low 4 of 16 sub-ticks. light=2 → low 12 of 16. Never more than one en bit low at once.
- Boundaries:
  - msg_len=0 → all num=7F and no wrap for 20 steps.
  - hold=1 for 3 steps → ptr unchanged.
  - Shrink msg_len from 6 to 2 while ptr=4 → ptr=0 at the next step, with a wrap pulse.
- Write/read collision: write addr 0 = 8 in the same cycle digit 0 is sampled → old value shown on that update, 8 (num=00) on the next digit-0 slot.
